tl_tx_credit_arbiter: RTL and testbench

Parametrised N-source TLP arbiter for the TL TX path. It sits between the TLP producers (AXI slave write/read request paths, AXI master completions, RX router completions/messages) and the data fragmentation buffer. It replaces fixed per-source arbitration with configurable source count, round-robin or fixed priority, and PCIe-exact flow-control credit gating per TLP type. After a grant it streams the winner's beats downstream with a ready/valid handshake.

---
 rtl/tl_tx_credit_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_tl_tx_credit_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_tx_credit_arbiter.sv
// rtl/tl_tx_credit_arbiter.sv - N-source TLP arbiter with per-type flow-control credit gating
//
// Purpose:
//   Picks one of NUM_SRC TLP producers (round-robin or fixed priority), but only
//   among sources whose TLP type has enough header and data credits. The winning
//   source gets a single-cycle grant pulse, its credit needs are charged to the
//   type's consumed counters, and its beats are then streamed downstream with a
//   ready/valid handshake until the beat flagged last is accepted.
//
// Ports:
//   clk, arst          clock, synchronous active-high reset
//   src_valid/type/has_data/len/data/last   per-source request and beat inputs
//   src_grant          one-hot grant pulse, one cycle after the eligible cycle
//   src_ready          beat accepted from the granted source
//   fc_upd_*           credit-limit/infinite-flag load for one TLP type
//   out_valid/sop/eop/data/src, out_ready   downstream beat stream
//   credit_blocked     source is requesting but lacks credits
module tl_tx_credit_arbiter #(
  parameter int NUM_SRC       = 4,
  parameter int DATA_W        = 128,
  parameter int FC_HDR_WIDTH  = 8,
  parameter int FC_DATA_WIDTH = 12,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [2*NUM_SRC-1:0]        src_type,
  input  logic [NUM_SRC-1:0]          src_has_data,
  input  logic [10*NUM_SRC-1:0]       src_len,
  input  logic [DATA_W*NUM_SRC-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_last,
  output logic [NUM_SRC-1:0]          src_grant,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic                        fc_upd_valid,
  input  logic [1:0]                  fc_upd_type,
  input  logic [FC_HDR_WIDTH-1:0]     fc_hdr_limit,
  input  logic [FC_DATA_WIDTH-1:0]    fc_data_limit,
  input  logic                        fc_hdr_inf,
  input  logic                        fc_data_inf,
  output logic                        out_valid,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(NUM_SRC)-1:0]  out_src,
  input  logic                        out_ready,
  output logic [NUM_SRC-1:0]          credit_blocked
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam logic [FC_HDR_WIDTH-1:0]  HDR_ONE   = {{(FC_HDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [FC_HDR_WIDTH-1:0]  HDR_HALF  = {1'b1, {(FC_HDR_WIDTH-1){1'b0}}};
  localparam logic [FC_DATA_WIDTH-1:0] DATA_HALF = {1'b1, {(FC_DATA_WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  // Data credits for a TLP: one credit per 4 DW, rounded up; len 0 means 1024 DW.
  function automatic logic [FC_DATA_WIDTH-1:0] data_need(input logic has_data,
                                                         input logic [9:0] len);
    logic [10:0] dw;
    dw = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    dw = (dw + 11'd3) >> 2;
    return has_data ? FC_DATA_WIDTH'(dw) : '0;
  endfunction

  state_t                   state_q;
  logic [IDX_W-1:0]         win_q;
  logic [IDX_W-1:0]         rr_ptr_q;
  logic [NUM_SRC-1:0]       grant_q;
  logic                     first_q;

  // Credit state indexed by TLP type; slot 3 (reserved type) is never loaded.
  logic [FC_HDR_WIDTH-1:0]  hdr_limit_q  [4];
  logic [FC_HDR_WIDTH-1:0]  hdr_cons_q   [4];
  logic [FC_DATA_WIDTH-1:0] data_limit_q [4];
  logic [FC_DATA_WIDTH-1:0] data_cons_q  [4];
  logic [3:0]               hdr_inf_q;
  logic [3:0]               data_inf_q;

  logic [1:0]               typ_a  [NUM_SRC];
  logic [FC_DATA_WIDTH-1:0] dneed  [NUM_SRC];
  logic [DATA_W-1:0]        sdata  [NUM_SRC];
  logic [NUM_SRC-1:0]       eligible;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [1:0]               typ;
    logic                     rsv;
    logic [FC_HDR_WIDTH-1:0]  hdr_room;
    logic [FC_DATA_WIDTH-1:0] data_room;
    logic                     hdr_ok;
    logic                     data_ok;

    assign typ       = src_type[2*g +: 2];
    assign rsv       = (typ == 2'b11);
    assign typ_a[g]  = typ;
    assign dneed[g]  = data_need(src_has_data[g], src_len[10*g +: 10]);
    assign sdata[g]  = src_data[DATA_W*g +: DATA_W];

    // Modular distance from (consumed + need) up to limit; a result in the
    // lower half of the counter range means the limit has not been passed,
    // which stays correct when consumed wraps.
    assign hdr_room  = hdr_limit_q[typ] - (hdr_cons_q[typ] + HDR_ONE);
    assign data_room = data_limit_q[typ] - (data_cons_q[typ] + dneed[g]);
    assign hdr_ok    = hdr_inf_q[typ]  | (hdr_room  <= HDR_HALF);
    assign data_ok   = data_inf_q[typ] | (data_room <= DATA_HALF);

    assign eligible[g]       = src_valid[g] & ~rsv & hdr_ok & data_ok;
    assign credit_blocked[g] = src_valid[g] & ~rsv & ~eligible[g];
  end

  logic [IDX_W-1:0]   win_d;
  logic               found;
  logic [IDX_W-1:0]   idx;

  always_comb begin
    win_d = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (PRIORITY_MODE != 0) idx = IDX_W'(k);
      else                    idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win_d = idx;
      end
    end
  end

  logic               any_elig;
  logic [NUM_SRC-1:0] win_oh;
  logic [1:0]         win_typ;
  logic [IDX_W-1:0]   rr_nxt;
  logic               xfer;
  logic               beat_acc;

  assign any_elig = |eligible;
  assign win_oh   = {{(NUM_SRC-1){1'b0}}, 1'b1} << win_d;
  assign win_typ  = typ_a[win_d];
  assign rr_nxt   = (win_d == IDX_W'(NUM_SRC-1)) ? '0 : win_d + 1'b1;
  assign xfer     = (state_q == S_XFER);
  assign beat_acc = xfer & src_valid[win_q] & out_ready;

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      first_q    <= 1'b0;
      hdr_inf_q  <= '0;
      data_inf_q <= '0;
      for (int t = 0; t < 4; t++) begin
        hdr_limit_q[t]  <= '0;
        hdr_cons_q[t]   <= '0;
        data_limit_q[t] <= '0;
        data_cons_q[t]  <= '0;
      end
    end else begin
      // Limit loads and consumption touch different registers, so both land
      // when they coincide; eligibility this cycle already used the old limits.
      if (fc_upd_valid && (fc_upd_type != 2'b11)) begin
        hdr_limit_q[fc_upd_type]  <= fc_hdr_limit;
        data_limit_q[fc_upd_type] <= fc_data_limit;
        hdr_inf_q[fc_upd_type]    <= fc_hdr_inf;
        data_inf_q[fc_upd_type]   <= fc_data_inf;
      end

      grant_q <= '0;

      case (state_q)
        S_IDLE: begin
          if (any_elig) begin
            state_q              <= S_XFER;
            win_q                <= win_d;
            grant_q              <= win_oh;
            first_q              <= 1'b1;
            rr_ptr_q             <= rr_nxt;
            hdr_cons_q[win_typ]  <= hdr_cons_q[win_typ] + HDR_ONE;
            data_cons_q[win_typ] <= data_cons_q[win_typ] + dneed[win_d];
          end
        end
        S_XFER: begin
          if (beat_acc) begin
            first_q <= 1'b0;
            if (src_last[win_q]) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign src_grant = grant_q;
  assign out_src   = win_q;
  assign out_valid = xfer & src_valid[win_q];
  assign out_sop   = out_valid & first_q;
  assign out_eop   = out_valid & src_last[win_q];
  assign out_data  = xfer ? sdata[win_q] : '0;
  assign src_ready = xfer ? ({{(NUM_SRC-1){1'b0}}, out_ready} << win_q) : '0;

endmodule

// File: tb/tb_tl_tx_credit_arbiter.sv
// tb/tb_tl_tx_credit_arbiter.sv - directed bench for tl_tx_credit_arbiter (round-robin and fixed instances)
module tb_tl_tx_credit_arbiter;

  localparam logic [1:0] T_P = 2'b00, T_NP = 2'b01, T_CPL = 2'b10;

  logic         clk;
  logic         arst;
  logic [3:0]   src_valid, src_has_data, src_last;
  logic [1:0]   typ_a [4];
  logic [9:0]   len_a [4];
  logic [127:0] dat_a [4];
  logic [7:0]   src_type;
  logic [39:0]  src_len;
  logic [511:0] src_data;
  logic         fc_upd_valid;
  logic [1:0]   fc_upd_type;
  logic [7:0]   fc_hdr_limit;
  logic [11:0]  fc_data_limit;
  logic         fc_hdr_inf, fc_data_inf;
  logic         out_ready;

  logic [3:0]   rr_grant, rr_ready, rr_blk, fx_grant, fx_ready, fx_blk;
  logic         rr_valid, rr_sop, rr_eop, fx_valid, fx_sop, fx_eop;
  logic [127:0] rr_data, fx_data;
  logic [1:0]   rr_src, fx_src;

  int n_pass  = 0;
  int n_total = 0;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign src_type[2*g +: 2]    = typ_a[g];
    assign src_len[10*g +: 10]   = len_a[g];
    assign src_data[128*g +: 128] = dat_a[g];
  end

  tl_tx_credit_arbiter #(.NUM_SRC(4), .DATA_W(128), .FC_HDR_WIDTH(8), .FC_DATA_WIDTH(12), .PRIORITY_MODE(0)) u_rr (
    .clk(clk), .arst(arst), .src_valid(src_valid), .src_type(src_type), .src_has_data(src_has_data),
    .src_len(src_len), .src_data(src_data), .src_last(src_last), .src_grant(rr_grant), .src_ready(rr_ready),
    .fc_upd_valid(fc_upd_valid), .fc_upd_type(fc_upd_type), .fc_hdr_limit(fc_hdr_limit),
    .fc_data_limit(fc_data_limit), .fc_hdr_inf(fc_hdr_inf), .fc_data_inf(fc_data_inf),
    .out_valid(rr_valid), .out_sop(rr_sop), .out_eop(rr_eop), .out_data(rr_data), .out_src(rr_src),
    .out_ready(out_ready), .credit_blocked(rr_blk));

  tl_tx_credit_arbiter #(.NUM_SRC(4), .DATA_W(128), .FC_HDR_WIDTH(8), .FC_DATA_WIDTH(12), .PRIORITY_MODE(1)) u_fx (
    .clk(clk), .arst(arst), .src_valid(src_valid), .src_type(src_type), .src_has_data(src_has_data),
    .src_len(src_len), .src_data(src_data), .src_last(src_last), .src_grant(fx_grant), .src_ready(fx_ready),
    .fc_upd_valid(fc_upd_valid), .fc_upd_type(fc_upd_type), .fc_hdr_limit(fc_hdr_limit),
    .fc_data_limit(fc_data_limit), .fc_hdr_inf(fc_hdr_inf), .fc_data_inf(fc_data_inf),
    .out_valid(fx_valid), .out_sop(fx_sop), .out_eop(fx_eop), .out_data(fx_data), .out_src(fx_src),
    .out_ready(out_ready), .credit_blocked(fx_blk));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [127:0] pat(input logic [1:0] i);
    logic [31:0] w;
    w = 32'hCAFE0000 | {30'd0, i};
    return {w, ~w, w, ~w};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src_valid = '0; src_has_data = '0; src_last = '0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      typ_a[k] = 2'b00; len_a[k] = 10'd0; dat_a[k] = '0;
    end
    fc_upd_valid = 1'b0; fc_upd_type = 2'b00; fc_hdr_limit = '0; fc_data_limit = '0;
    fc_hdr_inf = 1'b0; fc_data_inf = 1'b0;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    arst = 1'b0;
  endtask

  task automatic set_src(input logic [1:0] i, input logic v, input logic [1:0] t, input logic hd,
                         input logic [9:0] len, input logic last, input logic [127:0] d);
    src_valid[i] = v; typ_a[i] = t; src_has_data[i] = hd; len_a[i] = len; src_last[i] = last; dat_a[i] = d;
  endtask

  task automatic fc_update(input logic [1:0] t, input logic [7:0] h, input logic [11:0] d,
                           input logic hi, input logic di);
    fc_upd_valid = 1'b1; fc_upd_type = t; fc_hdr_limit = h; fc_data_limit = d;
    fc_hdr_inf = hi; fc_data_inf = di;
  endtask

  task automatic fc_clear();
    fc_upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_total++; if (rr_grant !== 4'b0000) $display("FAIL rst_grant got=%b exp=0000", rr_grant); else n_pass++;
    n_total++; if (rr_ready !== 4'b0000) $display("FAIL rst_ready got=%b exp=0000", rr_ready); else n_pass++;
    n_total++; if ({rr_valid, rr_sop, rr_eop} !== 3'b000) $display("FAIL rst_qual got=%b exp=000", {rr_valid, rr_sop, rr_eop}); else n_pass++;
    n_total++; if (rr_data !== 128'd0) $display("FAIL rst_data got=%h exp=0", rr_data); else n_pass++;
    n_total++; if (rr_src !== 2'd0) $display("FAIL rst_src got=%0d exp=0", rr_src); else n_pass++;
    n_total++; if (rr_blk !== 4'b0000) $display("FAIL rst_blk got=%b exp=0000", rr_blk); else n_pass++;
  endtask

  task automatic test_credit_gate();
    do_reset();
    set_src(2'd0, 1'b1, T_P, 1'b0, 10'd1, 1'b1, pat(2'd0));
    @(negedge clk);
    n_total++; if (rr_blk !== 4'b0001) $display("FAIL gate_blk0 got=%b exp=0001", rr_blk); else n_pass++;
    n_total++; if (rr_grant !== 4'b0000) $display("FAIL gate_nogrant0 got=%b exp=0000", rr_grant); else n_pass++;
    next_cycle(); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0000) $display("FAIL gate_nogrant1 got=%b exp=0000", rr_grant); else n_pass++;
    next_cycle(); fc_update(T_P, 8'd1, 12'd1, 1'b0, 1'b0); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0000) $display("FAIL gate_updcyc got=%b exp=0000", rr_grant); else n_pass++;
    next_cycle(); fc_clear(); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0000) $display("FAIL gate_elig_cyc got=%b exp=0000", rr_grant); else n_pass++;
    n_total++; if (rr_blk !== 4'b0000) $display("FAIL gate_blk1 got=%b exp=0000", rr_blk); else n_pass++;
    next_cycle(); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0001) $display("FAIL gate_grant got=%b exp=0001", rr_grant); else n_pass++;
    n_total++; if ({rr_valid, rr_sop, rr_eop} !== 3'b111) $display("FAIL gate_qual got=%b exp=111", {rr_valid, rr_sop, rr_eop}); else n_pass++;
    n_total++; if (rr_ready !== 4'b0001) $display("FAIL gate_ready got=%b exp=0001", rr_ready); else n_pass++;
    n_total++; if (rr_data !== pat(2'd0)) $display("FAIL gate_data got=%h exp=%h", rr_data, pat(2'd0)); else n_pass++;
    next_cycle(); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0000) $display("FAIL gate_after got=%b exp=0000", rr_grant); else n_pass++;
    n_total++; if (rr_blk !== 4'b0001) $display("FAIL gate_consumed got=%b exp=0001", rr_blk); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    do_reset();
    for (int k = 0; k < 4; k++) set_src(2'(k), 1'b1, T_NP, 1'b0, 10'd1, 1'b1, pat(2'(k)));
    fc_update(T_NP, 8'd0, 12'd0, 1'b1, 1'b0);
    @(negedge clk);
    n_total++; if (rr_blk !== 4'b1111) $display("FAIL rr_blk_pre got=%b exp=1111", rr_blk); else n_pass++;
    next_cycle(); fc_clear(); @(negedge clk);
    n_total++; if (rr_blk !== 4'b0000) $display("FAIL rr_blk_post got=%b exp=0000", rr_blk); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      next_cycle(); @(negedge clk);
      n_total++; if (rr_grant !== exp_oh) $display("FAIL rr_grant%0d got=%b exp=%b", k, rr_grant, exp_oh); else n_pass++;
      n_total++; if (rr_src !== 2'(k % 4)) $display("FAIL rr_src%0d got=%0d exp=%0d", k, rr_src, k % 4); else n_pass++;
      n_total++; if (rr_data !== pat(2'(k % 4))) $display("FAIL rr_data%0d got=%h exp=%h", k, rr_data, pat(2'(k % 4))); else n_pass++;
      n_total++; if (fx_grant !== 4'b0001) $display("FAIL fx_in_rr%0d got=%b exp=0001", k, fx_grant); else n_pass++;
      next_cycle(); @(negedge clk);
      n_total++; if (rr_grant !== 4'b0000) $display("FAIL rr_gap%0d got=%b exp=0000", k, rr_grant); else n_pass++;
      n_total++; if (rr_valid !== 1'b0) $display("FAIL rr_gapvalid%0d got=%b exp=0", k, rr_valid); else n_pass++;
    end
  endtask

  task automatic test_priority();
    do_reset();
    set_src(2'd1, 1'b1, T_NP, 1'b0, 10'd1, 1'b1, pat(2'd1));
    set_src(2'd3, 1'b1, T_NP, 1'b0, 10'd1, 1'b1, pat(2'd3));
    fc_update(T_NP, 8'd0, 12'd0, 1'b1, 1'b0);
    next_cycle(); fc_clear();
    for (int k = 0; k < 6; k++) begin
      next_cycle(); @(negedge clk);
      n_total++; if (fx_grant !== 4'b0010) $display("FAIL prio_fx%0d got=%b exp=0010", k, fx_grant); else n_pass++;
      n_total++; if (rr_grant !== ((k % 2 == 0) ? 4'b0010 : 4'b1000)) $display("FAIL prio_rr%0d got=%b exp=%b", k, rr_grant, (k % 2 == 0) ? 4'b0010 : 4'b1000); else n_pass++;
      next_cycle(); @(negedge clk);
      n_total++; if (fx_grant !== 4'b0000) $display("FAIL prio_gap%0d got=%b exp=0000", k, fx_grant); else n_pass++;
    end
  endtask

  task automatic test_data_boundary();
    do_reset();
    set_src(2'd0, 1'b1, T_P, 1'b1, 10'd16, 1'b1, pat(2'd0));
    fc_update(T_P, 8'd0, 12'd4, 1'b1, 1'b0);
    next_cycle(); fc_clear(); @(negedge clk);
    n_total++; if (rr_blk !== 4'b0000) $display("FAIL data_fit_blk got=%b exp=0000", rr_blk); else n_pass++;
    next_cycle(); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0001) $display("FAIL data_fit_grant got=%b exp=0001", rr_grant); else n_pass++;
    next_cycle(); len_a[0] = 10'd1; @(negedge clk);
    n_total++; if (rr_blk !== 4'b0001) $display("FAIL data_over_blk got=%b exp=0001", rr_blk); else n_pass++;
    next_cycle(); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0000) $display("FAIL data_over_grant got=%b exp=0000", rr_grant); else n_pass++;
    next_cycle(); fc_update(T_P, 8'd0, 12'd5, 1'b1, 1'b0); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0000) $display("FAIL data_upd_grant got=%b exp=0000", rr_grant); else n_pass++;
    next_cycle(); fc_clear(); @(negedge clk);
    n_total++; if (rr_blk !== 4'b0000) $display("FAIL data_upd_blk got=%b exp=0000", rr_blk); else n_pass++;
    next_cycle(); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0001) $display("FAIL data_upd_regrant got=%b exp=0001", rr_grant); else n_pass++;
  endtask

  task automatic test_len_zero();
    do_reset();
    set_src(2'd0, 1'b1, T_P, 1'b1, 10'd0, 1'b1, pat(2'd0));
    fc_update(T_P, 8'd0, 12'd255, 1'b1, 1'b0);
    next_cycle(); fc_clear(); @(negedge clk);
    n_total++; if (rr_blk !== 4'b0001) $display("FAIL len0_255_blk got=%b exp=0001", rr_blk); else n_pass++;
    next_cycle(); fc_update(T_P, 8'd0, 12'd256, 1'b1, 1'b0); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0000) $display("FAIL len0_255_grant got=%b exp=0000", rr_grant); else n_pass++;
    next_cycle(); fc_clear(); @(negedge clk);
    n_total++; if (rr_blk !== 4'b0000) $display("FAIL len0_256_blk got=%b exp=0000", rr_blk); else n_pass++;
    next_cycle(); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0001) $display("FAIL len0_256_grant got=%b exp=0001", rr_grant); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    set_src(2'd0, 1'b1, T_NP, 1'b0, 10'd1, 1'b1, pat(2'd0));
    fc_update(T_NP, 8'd0, 12'd0, 1'b1, 1'b0);
    next_cycle(); fc_clear();
    for (int k = 0; k < 255; k++) begin
      next_cycle(); @(negedge clk);
      n_total++; if (rr_grant !== 4'b0001) $display("FAIL wrap_fill%0d got=%b exp=0001", k, rr_grant); else n_pass++;
      next_cycle();
      if (k == 254) begin
        src_valid[0] = 1'b0;
        fc_update(T_NP, 8'd0, 12'd0, 1'b0, 1'b0);
      end
      @(negedge clk);
      n_total++; if (rr_grant !== 4'b0000) $display("FAIL wrap_gap%0d got=%b exp=0000", k, rr_grant); else n_pass++;
    end
    next_cycle(); fc_clear(); src_valid[0] = 1'b1; @(negedge clk);
    n_total++; if (rr_blk !== 4'b0000) $display("FAIL wrap_c255_blk got=%b exp=0000", rr_blk); else n_pass++;
    next_cycle(); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0001) $display("FAIL wrap_c255_grant got=%b exp=0001", rr_grant); else n_pass++;
    next_cycle(); @(negedge clk);
    n_total++; if (rr_blk !== 4'b0001) $display("FAIL wrap_c0_blk got=%b exp=0001", rr_blk); else n_pass++;
    next_cycle(); fc_update(T_NP, 8'd1, 12'd0, 1'b0, 1'b0); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0000) $display("FAIL wrap_c0_grant got=%b exp=0000", rr_grant); else n_pass++;
    next_cycle(); fc_clear(); @(negedge clk);
    n_total++; if (rr_blk !== 4'b0000) $display("FAIL wrap_l1_blk got=%b exp=0000", rr_blk); else n_pass++;
    next_cycle(); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0001) $display("FAIL wrap_l1_grant got=%b exp=0001", rr_grant); else n_pass++;
  endtask

  task automatic test_back_pressure();
    logic [127:0] b1, b2, b3;
    b1 = 128'h1111_0001_1111_0001_1111_0001_1111_0001;
    b2 = 128'h2222_0002_2222_0002_2222_0002_2222_0002;
    b3 = 128'h3333_0003_3333_0003_3333_0003_3333_0003;
    do_reset();
    set_src(2'd2, 1'b1, T_CPL, 1'b1, 10'd8, 1'b0, b1);
    fc_update(T_CPL, 8'd0, 12'd0, 1'b1, 1'b1);
    next_cycle(); fc_clear();
    next_cycle(); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0100) $display("FAIL bp_grant got=%b exp=0100", rr_grant); else n_pass++;
    n_total++; if (rr_src !== 2'd2) $display("FAIL bp_src got=%0d exp=2", rr_src); else n_pass++;
    n_total++; if ({rr_valid, rr_sop, rr_eop} !== 3'b110) $display("FAIL bp_b1_qual got=%b exp=110", {rr_valid, rr_sop, rr_eop}); else n_pass++;
    n_total++; if (rr_data !== b1) $display("FAIL bp_b1_data got=%h exp=%h", rr_data, b1); else n_pass++;
    n_total++; if (rr_ready !== 4'b0100) $display("FAIL bp_b1_ready got=%b exp=0100", rr_ready); else n_pass++;
    next_cycle(); dat_a[2] = b2; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      n_total++; if ({rr_valid, rr_sop, rr_eop} !== 3'b100) $display("FAIL bp_hold%0d_qual got=%b exp=100", k, {rr_valid, rr_sop, rr_eop}); else n_pass++;
      n_total++; if (rr_data !== b2) $display("FAIL bp_hold%0d_data got=%h exp=%h", k, rr_data, b2); else n_pass++;
      n_total++; if (rr_ready !== 4'b0000) $display("FAIL bp_hold%0d_ready got=%b exp=0000", k, rr_ready); else n_pass++;
    end
    next_cycle(); out_ready = 1'b1; @(negedge clk);
    n_total++; if ({rr_valid, rr_sop, rr_eop} !== 3'b100) $display("FAIL bp_b2_qual got=%b exp=100", {rr_valid, rr_sop, rr_eop}); else n_pass++;
    n_total++; if (rr_ready !== 4'b0100) $display("FAIL bp_b2_ready got=%b exp=0100", rr_ready); else n_pass++;
    next_cycle(); dat_a[2] = b3; src_last[2] = 1'b1; @(negedge clk);
    n_total++; if ({rr_valid, rr_sop, rr_eop} !== 3'b101) $display("FAIL bp_b3_qual got=%b exp=101", {rr_valid, rr_sop, rr_eop}); else n_pass++;
    n_total++; if (rr_data !== b3) $display("FAIL bp_b3_data got=%h exp=%h", rr_data, b3); else n_pass++;
    next_cycle(); src_last[2] = 1'b0; dat_a[2] = b1; @(negedge clk);
    n_total++; if (rr_valid !== 1'b0) $display("FAIL bp_idle_valid got=%b exp=0", rr_valid); else n_pass++;
    n_total++; if (rr_grant !== 4'b0000) $display("FAIL bp_idle_grant got=%b exp=0000", rr_grant); else n_pass++;
    next_cycle(); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0100) $display("FAIL bp_regrant got=%b exp=0100", rr_grant); else n_pass++;
    n_total++; if (rr_sop !== 1'b1) $display("FAIL bp_regrant_sop got=%b exp=1", rr_sop); else n_pass++;
    next_cycle(); arst = 1'b1; dat_a[2] = b2;
    next_cycle(); arst = 1'b0; @(negedge clk);
    n_total++; if ({rr_valid, rr_sop, rr_eop} !== 3'b000) $display("FAIL midrst_qual got=%b exp=000", {rr_valid, rr_sop, rr_eop}); else n_pass++;
    n_total++; if (rr_data !== 128'd0) $display("FAIL midrst_data got=%h exp=0", rr_data); else n_pass++;
    n_total++; if (rr_ready !== 4'b0000) $display("FAIL midrst_ready got=%b exp=0000", rr_ready); else n_pass++;
    n_total++; if (rr_grant !== 4'b0000) $display("FAIL midrst_grant got=%b exp=0000", rr_grant); else n_pass++;
    n_total++; if (rr_src !== 2'd0) $display("FAIL midrst_src got=%0d exp=0", rr_src); else n_pass++;
    next_cycle(); @(negedge clk);
    n_total++; if (rr_grant !== 4'b0000) $display("FAIL midrst_nocredit got=%b exp=0000", rr_grant); else n_pass++;
  endtask

  initial begin
    arst = 1'b1;
    clear_inputs();
    test_reset();
    test_credit_gate();
    test_round_robin();
    test_priority();
    test_data_boundary();
    test_len_zero();
    test_wrap();
    test_back_pressure();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
